// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and iteration-counter sizing.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Counter must hold the value WIDTH itself, hence the +1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, and keep the difference only if it did not underflow.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-2:0] rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] partial;

  always_comb begin
    partial = {rem_in, dividend_msb};
    q_bit   = (partial >= divisor);
    rem_out = q_bit ? (partial - divisor) : partial;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_FLAG_EN adds a div_zero output flagging a zero divisor.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [WIDTH-1:0]   op_A,
  input  logic [WIDTH-1:0]   op_B,
  output logic [2*WIDTH-1:0] result,
  output logic               done
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               div_zero
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state;
  logic             init_q;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] divisor;
  // Dividend bits shift out the top while quotient bits shift in at the bottom;
  // after WIDTH steps this register holds the full quotient.
  logic [WIDTH-1:0] dq;
  // Before step k the remainder is below 2^(k-1), so its MSB is always zero
  // while iterating; only the final step's rem_out needs the full width.
  logic [WIDTH-2:0] rem;

  logic             start;
  logic [WIDTH-1:0] rem_out;
  logic             q_bit;

  assign start = init & ~init_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem),
    .dividend_msb (dq[WIDTH-1]),
    .divisor      (divisor),
    .rem_out      (rem_out),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      init_q   <= 1'b0;
      counter  <= '0;
      divisor  <= '0;
      dq       <= '0;
      rem      <= '0;
      result   <= '0;
      done     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      init_q <= init;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dq       <= op_A;
            divisor  <= op_B;
            rem      <= '0;
            counter  <= CNT_W'(WIDTH);
            done     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero <= 1'b0;
`endif
            state    <= CALC;
          end
        end
        CALC: begin
          rem     <= rem_out[WIDTH-2:0];
          dq      <= {dq[WIDTH-2:0], q_bit};
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            result   <= {rem_out, dq[WIDTH-2:0], q_bit};
            done     <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            div_zero <= (divisor == '0);
`endif
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=16); inputs change and
// outputs are sampled on the falling clock edge.
module tb_seq_divider;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           init;
  logic [W-1:0]   op_A;
  logic [W-1:0]   op_B;
  logic [2*W-1:0] result;
  logic           done;
`ifdef DIV_ZERO_FLAG_EN
  logic           div_zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .op_A     (op_A),
    .op_B     (op_B),
    .result   (result),
    .done     (done)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  // One-cycle init pulse; returns at the falling edge right after the start edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_A = a;
    op_B = b;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Counts rising edges since the start edge until done; bounded at 40.
  task automatic wait_done(input int start_cyc, output int lat);
    lat = start_cyc;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    init  = 1'b0;
    op_A  = '0;
    op_B  = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", done);
    end
    n_tests++;
    if (result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    @(negedge clk);
    op_A = 16'hC86C;
    op_B = 16'h00CA;
    init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    init = 1'b0;
    n_tests++;
    if (done !== 1'b0 || result !== 32'h0) begin
      n_fail++; $display("FAIL basic_calc_hold: got done=%b result=%h expected 0/00000000", done, result);
    end
    wait_done(1, lat);
    n_tests++;
    if (lat !== 16) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 16", lat);
    end
    n_tests++;
    if (result !== 32'h000000FE) begin
      n_fail++; $display("FAIL basic_result: got %h expected 000000fe", result);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || result !== 32'h000000FE) begin
      n_fail++; $display("FAIL basic_hold: got done=%b result=%h expected 1/000000fe", done, result);
    end
  endtask

  task automatic test_div7;
    int lat;
    launch(16'hFFFF, 16'h0007);
    wait_done(0, lat);
    n_tests++;
    if (lat !== 16) begin
      n_fail++; $display("FAIL div7_latency: got %0d expected 16", lat);
    end
    // 65535 = 7*9362 + 1
    n_tests++;
    if (result !== 32'h00012492) begin
      n_fail++; $display("FAIL div7_result: got %h expected 00012492", result);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    launch(16'h1234, 16'h0000);
    wait_done(0, lat);
    n_tests++;
    if (lat !== 16) begin
      n_fail++; $display("FAIL divzero_latency: got %0d expected 16", lat);
    end
    n_tests++;
    if (result !== 32'h1234FFFF) begin
      n_fail++; $display("FAIL divzero_result: got %h expected 1234ffff", result);
    end
`ifdef DIV_ZERO_FLAG_EN
    n_tests++;
    if (div_zero !== 1'b1) begin
      n_fail++; $display("FAIL divzero_flag: got %b expected 1", div_zero);
    end
`endif
  endtask

  task automatic test_op_change;
    int lat;
    launch(16'h0005, 16'h0009);
`ifdef DIV_ZERO_FLAG_EN
    n_tests++;
    if (div_zero !== 1'b0) begin
      n_fail++; $display("FAIL divzero_clear: got %b expected 0", div_zero);
    end
`endif
    repeat (3) @(negedge clk);
    op_A = 16'hFFFF;
    op_B = 16'h0001;
    wait_done(3, lat);
    n_tests++;
    if (lat !== 16) begin
      n_fail++; $display("FAIL opchange_latency: got %0d expected 16", lat);
    end
    n_tests++;
    if (result !== 32'h00050000) begin
      n_fail++; $display("FAIL opchange_result: got %h expected 00050000", result);
    end
  endtask

  task automatic test_ignore_restart;
    int lat;
    launch(16'hFFFF, 16'h0007);
    repeat (4) @(negedge clk);
    op_A = 16'h0100;
    op_B = 16'h0002;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_done(5, lat);
    n_tests++;
    if (lat !== 16) begin
      n_fail++; $display("FAIL ignore_latency: got %0d expected 16", lat);
    end
    n_tests++;
    if (result !== 32'h00012492) begin
      n_fail++; $display("FAIL ignore_result: got %h expected 00012492", result);
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || result !== 32'h00012492) begin
      n_fail++; $display("FAIL ignore_not_queued: got done=%b result=%h expected 1/00012492", done, result);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(16'hC86C, 16'h00CA);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done_drop: got %b expected 0", done);
    end
    wait_done(0, lat);
    n_tests++;
    if (lat !== 16 || result !== 32'h000000FE) begin
      n_fail++; $display("FAIL b2b_result: got lat=%0d result=%h expected 16/000000fe", lat, result);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    launch(16'h1234, 16'h0000);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || result !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_clear: got done=%b result=%h expected 0/00000000", done, result);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: got %b expected 0", done);
    end
    // Reset and init together: reset wins, no division may start.
    op_A  = 16'h0005;
    op_B  = 16'h0009;
    reset = 1'b1;
    init  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    init  = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || result !== 32'h0) begin
      n_fail++; $display("FAIL rst_priority: got done=%b result=%h expected 0/00000000", done, result);
    end
    launch(16'hFFFF, 16'h0007);
    wait_done(0, lat);
    n_tests++;
    if (lat !== 16 || result !== 32'h00012492) begin
      n_fail++; $display("FAIL rstmid_recover: got lat=%0d result=%h expected 16/00012492", lat, result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div7();
    test_div_zero();
    test_op_change();
    test_ignore_restart();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
